// File: rtl/jtag_host.sv
// JTAG host: shifts up to 32 TMS/TDI bits per command and returns the captured TDO bits.
// TCK is produced from clk_i, with each half-period lasting ClkDiv clk_i cycles.
module jtag_host #(
  parameter int ClkDiv = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [5:0]  req_len_i,
  input  logic [31:0] req_tms_i,
  input  logic [31:0] req_tdi_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_tdo_o,
  input  logic        trst_i,
  output logic        busy_o,
  output logic        jtag_tck_o,
  output logic        jtag_tms_o,
  output logic        jtag_tdi_o,
  output logic        jtag_trst_no,
  input  logic        jtag_tdo_i
);

  localparam int CntW = $clog2(ClkDiv + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(ClkDiv - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_rsp_valid;
  logic            r_busy;
  logic            r_tck;
  logic            r_tms;
  logic            r_tdi;
  logic            r_trst_n;
  logic [31:0]     r_tdo;
  logic [31:0]     r_tms_sh;
  logic [31:0]     r_tdi_sh;
  logic [CntW-1:0] r_cnt;
  logic [5:0]      r_bit;
  logic [5:0]      r_len;

  logic [5:0]      w_len_clamp;
  logic [5:0]      w_next_bit;
  logic            w_last;

  assign w_len_clamp = (req_len_i > 6'd32) ? 6'd32 : req_len_i;
  assign w_next_bit  = r_bit + 6'd1;
  assign w_last      = (w_next_bit == r_len);

  assign req_ready_o  = r_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_tdo_o    = r_tdo;
  assign busy_o       = r_busy;
  assign jtag_tck_o   = r_tck;
  assign jtag_tms_o   = r_tms;
  assign jtag_tdi_o   = r_tdi;
  assign jtag_trst_no = r_trst_n;

  // TAP reset only passes through a register; it never touches the shift engine.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_trst_n <= 1'b0;
    else       r_trst_n <= ~trst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_tdo       <= '0;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_len       <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (r_ready && req_valid_i) begin
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_len    <= w_len_clamp;
            r_tms_sh <= req_tms_i;
            r_tdi_sh <= req_tdi_i;
            r_tdo    <= '0;
            r_bit    <= '0;
            r_cnt    <= CntLoad;
            if (w_len_clamp == 6'd0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state <= LOW;
              r_tck   <= 1'b0;
              r_tms   <= req_tms_i[0];
              r_tdi   <= req_tdi_i[0];
            end
          end
        end
        LOW: begin
          if (r_cnt == '0) begin
            r_state <= HIGH;
            r_tck   <= 1'b1;
            r_cnt   <= CntLoad;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        HIGH: begin
          if (r_cnt == '0) begin
            r_tck             <= 1'b0;
            r_tdo[r_bit[4:0]] <= jtag_tdo_i;
            r_cnt             <= CntLoad;
            if (w_last) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else begin
              // Shift registers advance so bit 1 is always the next bit to drive.
              r_state  <= LOW;
              r_bit    <= w_next_bit;
              r_tms    <= r_tms_sh[1];
              r_tdi    <= r_tdi_sh[1];
              r_tms_sh <= r_tms_sh >> 1;
              r_tdi_sh <= r_tdi_sh >> 1;
            end
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        RESP: begin
          r_tck <= 1'b0;
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Directed self-checking bench for jtag_host with ClkDiv=2 (4 clk cycles per TCK bit).
module tb_jtag_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_len = '0;
  logic [31:0] req_tms = '0;
  logic [31:0] req_tdi = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_tdo;
  logic        trst = 1'b0;
  logic        busy;
  logic        tck, tms, tdi, trst_n;
  logic        tdo = 1'b0;

  int errors = 0;
  int checks = 0;

  int          o_lat;
  int          o_pulses;
  bit          o_timing_ok;
  bit          o_bits_ok;
  bit          o_trst_ok;
  int          o_trst_lows;
  logic        o_end_tms;
  logic        o_end_tdi;
  logic        o_end_tck;

  jtag_host #(.ClkDiv(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_len_i(req_len), .req_tms_i(req_tms), .req_tdi_i(req_tdi),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_tdo_o(rsp_tdo),
    .trst_i(trst), .busy_o(busy),
    .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
    .jtag_trst_no(trst_n), .jtag_tdo_i(tdo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Waits for ready, presents one command; returns just after handshake edge E.
  task automatic send(input logic [5:0] len, input logic [31:0] t, input logic [31:0] d);
    int w = 0;
    while (!req_ready && w < 50) begin tick(); w++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready: req_ready=%b required 1", req_ready);
    end
    req_len = len; req_tms = t; req_tdi = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Target model plus observer, starting at sample point E (cycle 0).
  task automatic observe(input logic [31:0] t, input logic [31:0] d, input logic [31:0] pat,
                         input int trst_start);
    int   cyc = 0;
    int   rises = 0;
    logic prev_tck = 1'b0;
    logic trst_last = trst;
    o_lat = -1; o_timing_ok = 1; o_bits_ok = 1; o_trst_ok = 1; o_trst_lows = 0;
    while (cyc <= 200) begin
      if (trst_n !== ~trst_last) o_trst_ok = 0;
      if (trst_n === 1'b0) o_trst_lows++;
      if (rsp_valid === 1'b1) begin o_lat = cyc; break; end
      if (tck === 1'b1 && prev_tck === 1'b0) rises++;
      if (tck !== ((cyc % 4) >= 2)) o_timing_ok = 0;
      if ((cyc / 4) < 32 && (tms !== t[cyc/4] || tdi !== d[cyc/4])) o_bits_ok = 0;
      trst = (cyc >= trst_start && cyc < trst_start + 5);
      trst_last = trst;
      tdo = (rises > 0) ? pat[rises-1] : 1'b0;
      prev_tck = tck;
      tick();
      cyc++;
    end
    trst = 1'b0;
    o_pulses = rises;
    o_end_tms = tms; o_end_tdi = tdi; o_end_tck = tck;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rsp_done: ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({tck, tms, tdi, trst_n, req_ready, rsp_valid, busy} !== 7'b0100000 || rsp_tdo !== 32'h0) begin
        errors++;
        $display("FAIL reset_vals cyc%0d: tck/tms/tdi/trstn/rdy/vld/busy=%b tdo=%h required 0100000 tdo=0",
                 i, {tck, tms, tdi, trst_n, req_ready, rsp_valid, busy}, rsp_tdo);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: %b required 1", req_ready); end
  endtask

  task automatic test_tap_reset();
    send(6'd5, 32'h1F, 32'h0);
    observe(32'h1F, 32'h0, 32'h0, -100);
    checks++; if (o_lat != 20) begin errors++; $display("FAIL tap_latency: %0d required 20", o_lat); end
    checks++; if (o_pulses != 5) begin errors++; $display("FAIL tap_pulses: %0d required 5", o_pulses); end
    checks++; if (!o_timing_ok) begin errors++; $display("FAIL tap_tck_timing: bad=%0d required ok", 1); end
    checks++; if (!o_bits_ok || o_end_tms !== 1'b1) begin
      errors++; $display("FAIL tap_tms: bits_ok=%0d end_tms=%b required 1/1", o_bits_ok, o_end_tms); end
    checks++; if (rsp_tdo !== 32'h0) begin errors++; $display("FAIL tap_tdo: %h required 0", rsp_tdo); end
    finish_rsp();
  endtask

  task automatic test_idcode();
    send(6'd32, 32'h8000_0000, 32'h0);
    observe(32'h8000_0000, 32'h0, 32'h1234_5679, -100);
    checks++; if (o_lat != 128) begin errors++; $display("FAIL idcode_latency: %0d required 128", o_lat); end
    checks++; if (!o_bits_ok || o_end_tms !== 1'b1 || o_end_tck !== 1'b0) begin
      errors++; $display("FAIL idcode_tms: bits_ok=%0d end_tms=%b tck=%b required 1/1/0", o_bits_ok, o_end_tms, o_end_tck); end
    checks++; if (rsp_tdo !== 32'h1234_5679) begin errors++; $display("FAIL idcode_tdo: %h required 12345679", rsp_tdo); end
    finish_rsp();
  endtask

  task automatic test_boundary();
    send(6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    observe(32'h0, 32'h0, 32'h0, -100);
    checks++; if (o_lat != 0 || o_pulses != 0 || rsp_tdo !== 32'h0 || tck !== 1'b0) begin
      errors++; $display("FAIL len0: lat=%0d pulses=%0d tdo=%h tck=%b required 0/0/0/0", o_lat, o_pulses, rsp_tdo, tck); end
    finish_rsp();
    send(6'd40, 32'h0, 32'hA5A5_A5A5);
    observe(32'h0, 32'hA5A5_A5A5, 32'hCAFE_F00D, -100);
    checks++; if (o_lat != 128 || o_pulses != 32) begin
      errors++; $display("FAIL len40: lat=%0d pulses=%0d required 128/32", o_lat, o_pulses); end
    checks++; if (rsp_tdo !== 32'hCAFE_F00D || !o_bits_ok) begin
      errors++; $display("FAIL len40_data: tdo=%h bits_ok=%0d required cafef00d/1", rsp_tdo, o_bits_ok); end
    finish_rsp();
    send(6'd1, 32'h0, 32'h1);
    observe(32'h0, 32'h1, 32'h1, -100);
    checks++; if (o_lat != 4 || rsp_tdo !== 32'h1 || o_end_tdi !== 1'b1) begin
      errors++; $display("FAIL len1: lat=%0d tdo=%h tdi=%b required 4/1/1", o_lat, rsp_tdo, o_end_tdi); end
    finish_rsp();
    send(6'd5, 32'h0, 32'h0);
    observe(32'h0, 32'h0, 32'hFFFF_FFFF, -100);
    checks++; if (rsp_tdo !== 32'h0000_001F) begin
      errors++; $display("FAIL upper_tdo_zero: %h required 0000001f", rsp_tdo); end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    bit held_ok = 1;
    send(6'd3, 32'h7, 32'h2);
    observe(32'h7, 32'h2, 32'h5, -100);
    checks++; if (o_lat != 12 || rsp_tdo !== 32'h5) begin
      errors++; $display("FAIL bp_first: lat=%0d tdo=%h required 12/5", o_lat, rsp_tdo); end
    req_len = 6'd2; req_tms = 32'h2; req_tdi = 32'h1; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_tdo !== 32'h5 || tck !== 1'b0 || req_ready !== 1'b0) held_ok = 0;
    end
    checks++; if (!held_ok) begin
      errors++; $display("FAIL bp_hold: vld=%b tdo=%h tck=%b rdy=%b required 1/5/0/0", rsp_valid, rsp_tdo, tck, req_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: rdy=%b vld=%b busy=%b required 1/0/0", req_ready, rsp_valid, busy); end
    tick();
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept: busy=%b rdy=%b required 1/0", busy, req_ready); end
    observe(32'h2, 32'h1, 32'h3, -100);
    checks++; if (o_lat != 8 || rsp_tdo !== 32'h3 || !o_bits_ok) begin
      errors++; $display("FAIL bp_second: lat=%0d tdo=%h bits_ok=%0d required 8/3/1", o_lat, rsp_tdo, o_bits_ok); end
    finish_rsp();
  endtask

  task automatic test_midshift_reset();
    bit seen = 0;
    send(6'd8, 32'h0, 32'hFF);
    for (int i = 0; i < 14; i++) tick();
    checks++; if (tck !== 1'b1 || tms !== 1'b0) begin
      errors++; $display("FAIL mid_pre: tck=%b tms=%b required 1/0", tck, tms); end
    rst = 1'b1;
    tick();
    checks++; if (tck !== 1'b0 || tms !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_abort: tck=%b tms=%b vld=%b busy=%b required 0/1/0/0", tck, tms, rsp_valid, busy); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: %b required 1", req_ready); end
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid !== 1'b0) seen = 1;
      tick();
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_no_rsp: rsp_valid seen=%0d required 0", seen); end
  endtask

  task automatic test_trst();
    send(6'd8, 32'h5A, 32'hC3);
    observe(32'h5A, 32'hC3, 32'hA5, 5);
    checks++; if (!o_trst_ok || o_trst_lows != 5) begin
      errors++; $display("FAIL trst_pin: ok=%0d lows=%0d required 1/5", o_trst_ok, o_trst_lows); end
    checks++; if (o_lat != 32 || rsp_tdo !== 32'hA5 || !o_timing_ok || !o_bits_ok) begin
      errors++; $display("FAIL trst_shift: lat=%0d tdo=%h timing=%0d bits=%0d required 32/a5/1/1",
                         o_lat, rsp_tdo, o_timing_ok, o_bits_ok); end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_idcode();
    test_boundary();
    test_back_to_back();
    test_midshift_reset();
    test_trst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 Parameter ClkDiv, default 2, SHALL set the clk_i cycles per TCK half-period; legal range 1..255.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset; SHALL be synchronous and active-high.
REQ-004 req_valid_i  in  1  command valid.
REQ-005 req_ready_o  out  1  command accepted when high together with req_valid_i.
REQ-006 req_len_i  in  6  number of TCK bits to shift.
REQ-007 req_tms_i  in  32  TMS bit per TCK, LSB first.
REQ-008 req_tdi_i  in  32  TDI bit per TCK, LSB first.
REQ-009 rsp_valid_o  out  1  response valid.
REQ-010 rsp_ready_i  in  1  response consumed.
REQ-011 rsp_tdo_o  out  32  captured TDO bits, LSB first.
REQ-012 trst_i  in  1  level request to assert TAP reset.
REQ-013 busy_o  out  1  high whenever the FSM is not IDLE.
REQ-014 jtag_tck_o, jtag_tms_o, jtag_tdi_o  out  1 each  JTAG drive to target; jtag_trst_no  out  1  active-low TAP reset; jtag_tdo_i  in  1  target TDO.

Function
REQ-015 The FSM SHALL have the states IDLE, LOW, HIGH and RESP.
REQ-016 In IDLE, req_ready_o SHALL be 1; in all other states it SHALL be 0.
REQ-017 On handshake edge E, the block SHALL latch the length, clamped so that len>32 becomes 32, together with the TMS and TDI vectors, and SHALL clear the TDO shift register.
REQ-018 If len==0, the FSM SHALL go from IDLE to RESP on E, with rsp_tdo_o=0 and no TCK pulse.
REQ-019 If len>=1, the FSM SHALL enter LOW on E, with jtag_tms_o and jtag_tdi_o set to bit 0 and jtag_tck_o=0.
REQ-020 LOW SHALL last ClkDiv cycles and then enter HIGH, setting jtag_tck_o=1.
REQ-021 HIGH SHALL last ClkDiv cycles; on the edge that ends HIGH, the block SHALL set jtag_tck_o=0 and store jtag_tdo_i into bit i of the TDO register.
REQ-022 On that same edge, if bits remain, the FSM SHALL enter LOW with TMS/TDI set to bit i+1; otherwise it SHALL enter RESP.
REQ-023 For len N>=1, rsp_valid_o SHALL rise exactly 2*N*ClkDiv cycles after E, producing exactly N TCK pulses.
REQ-024 After the last bit, jtag_tms_o and jtag_tdi_o SHALL hold that bit's values until the next command.
REQ-025 rsp_tdo_o bits at or above N SHALL be 0.
REQ-026 In RESP, rsp_valid_o SHALL be 1 and rsp_tdo_o stable, with jtag_tck_o held at 0.
REQ-027 The FSM SHALL leave RESP for IDLE only on the edge where rsp_valid_o and rsp_ready_i are both high.
REQ-028 After the response handshake, req_ready_o SHALL be high the following cycle.
REQ-029 req_valid_i SHALL be ignored outside IDLE.
REQ-030 jtag_trst_no SHALL be the registered inverse of trst_i, with one cycle of latency.
REQ-031 trst_i SHALL NOT affect the FSM or an in-progress shift.
REQ-032 A single internal half-period counter of width ceil(log2(ClkDiv+1)) SHALL reload on every phase change.
REQ-033 A bit counter of 6 bits SHALL count bits shifted; neither counter SHALL wrap within a command.

Reset
REQ-034 While rst_i is high, the block SHALL drive: jtag_tck_o=0, jtag_tms_o=1, jtag_tdi_o=0, jtag_trst_no=0, req_ready_o=0, rsp_valid_o=0, rsp_tdo_o=0, busy_o=0.
REQ-035 While rst_i is high, the FSM SHALL be in IDLE.
REQ-036 Reset asserted mid-shift or in RESP SHALL abort the command on the next edge with no response produced.
REQ-037 req_ready_o SHALL rise on the first edge after rst_i falls.

Verification (ClkDiv=2)
REQ-038 Reset: pulse rst_i for 3 cycles -> reset values of REQ-034 hold throughout; req_ready_o=1 on the first cycle after release.
REQ-039 TAP reset sequence: len=5, tms=0x1F, tdi=0 -> 5 TCK pulses, each 2 cycles low then 2 cycles high; TMS=1 throughout; rsp_valid_o at E+20; rsp_tdo_o=0x0000_0000 with TDO tied 0.
REQ-040 IDCODE scan: len=32, tms=0x8000_0000, target model returns 0x1234_5679 LSB first -> TMS=1 only during bit 31; rsp_valid_o at E+128; rsp_tdo_o=0x1234_5679.
REQ-041 Boundary lengths: len=0 -> rsp_valid_o on E with no TCK edge and tdo=0; len=40 -> exactly 32 pulses and rsp_valid_o at E+128; len=1 with TDO=1 -> rsp_tdo_o=0x1 at E+4.
REQ-042 Backpressure: rsp_ready_i held 0 for 10 cycles while req_valid_i=1 -> rsp_valid_o=1, rsp_tdo_o stable, tck=0, req_ready_o=0; after rsp_ready_i=1, the new command is accepted 1 cycle later.
REQ-043 Mid-shift reset: rst_i asserted after 3 bits of a len=8 command -> tck=0 and tms=1 on the next edge; rsp_valid_o never asserts.
REQ-044 TRST: trst_i=1 for 5 cycles during a shift -> jtag_trst_no low for 5 cycles delayed by 1; shift timing and result unchanged.
